wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter directly upstream of the register file's single write port (`we`/`waddr`/`wdata`). It merges the single-cycle primary result (ALU/load) with results from multi-cycle units (mult/div, coprocessor) that arrive on a valid/ready handshake. Late results are buffered in a small FIFO, and the block reports which registers have buffered writes so decode can detect hazards.

## Interface
- `DEPTH`, 4: secondary FIFO entries; power of two, ≥2.
- `DW`, 32: data width.
- `AW`, 5: register address width.
- `STARVE_MAX`, 8: consecutive primary wins with a non-empty FIFO before a stall is requested.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_s` in 1: reset, asynchronous, active-high.
- `pri_we` in 1: primary write request.
- `pri_waddr` in AW: primary destination register.
- `pri_wdata` in DW: primary data.
- `sec_valid` in 1: secondary result valid.
- `sec_ready` out 1: secondary accept, = !full && !rst_s.
- `sec_waddr` in AW: secondary destination.
- `sec_wdata` in DW: secondary data.
- `we` out 1: regfile write enable.
- `waddr` out AW: regfile write address.
- `wdata` out DW: regfile write data.
- `busy_mask` out 2^AW: bit r set iff a valid FIFO entry targets register r; bit 0 always 0.
- `fifo_count` out clog2(DEPTH)+1: occupied entries.
- `stall_req` out 1: upstream must suppress `pri_we` until it drops.

## Operation
- Primary is effective when `pri_we && pri_waddr != 0`. A primary write to r0 counts as no request.
- Output selection is combinational each cycle, in priority order:
  1. Effective primary: `we=1`, outputs = `pri_*`. No pop.
  2. FIFO non-empty: pop the head; `we=1`, outputs = head entry.
  3. Otherwise `we=0`, `waddr=0`, `wdata=0` (except bypass, see Configuration).
- Secondary handshake completes when `sec_valid && sec_ready`. If `sec_waddr == 0`, the handshake completes and the data is discarded, not enqueued. Otherwise the entry is pushed at the tail.
- When full, `sec_ready=0` even if a pop happens in the same cycle; there is no push-through at full.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged and keeps pointers consistent.
- Pointers wrap modulo DEPTH. Entries leave strictly in FIFO order.
- Duplicate addresses in the FIFO are allowed. `busy_mask` is the OR of the decoded addresses of all valid entries, so a bit stays set until the last matching entry pops. The mask is derived from registered state only; it does not reflect same-cycle input.
- `starve_cnt`:
  - increments, saturating at STARVE_MAX, each cycle an effective primary write occurs while the FIFO is non-empty;
  - clears on any pop or when the FIFO is empty.
- `stall_req = (count == DEPTH) || (starve_cnt == STARVE_MAX)`. This is a request only; the arbiter never blocks primary writes.

## Timing
- Primary to regfile: 0 cycles. The write lands on the same rising edge.
- Secondary accepted at edge N: written at edge N+1 at the earliest, if no primary is present.
- `busy_mask`, `fifo_count`, and `stall_req` update one edge after a push or pop.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO emptied, pointers and `starve_cnt` set to 0;
  - `we=0`, `waddr=0`, `wdata=0`, `busy_mask=0`, `fifo_count=0`, `stall_req=0`, `sec_ready=0` while `rst_s` is high;
  - buffered entries are lost;
  - the first push is possible on the first edge after `rst_s` falls.

## Configuration
- Macro `WB_SEC_BYPASS_EN`.
- Defined: if there is no effective primary, the FIFO is empty, and the secondary handshake completes with a nonzero address, the secondary drives `we`/`waddr`/`wdata` directly on that edge and is not enqueued. Latency is 0 cycles.
- Undefined: every accepted secondary passes through the FIFO. Minimum latency is 1 cycle.

## Test plan
- Reset then idle: `rst_s=1` → all outputs 0, `sec_ready=0`; after release, `sec_ready=1`, `we=0`.
- Primary-only: `pri_we=1`, addr 5, data 10 → `we=1`, `waddr=5`, `wdata=10` the same cycle. Addr 0 → `we=0`.
- Contention: the primary holds r6/1 for 3 cycles while the secondary pushes r7/0xAA. The secondary writes in the first cycle with `pri_we=0`. `busy_mask[7]` is 1 until the edge after the pop.
- Fill: push 4 entries (r1..r4) under continuous primary → `fifo_count=4`, `sec_ready=0`, `stall_req=1`. Drop the primary → writes r1..r4 in order over 4 cycles, then `we=0`.
- Starvation: 1 buffered entry with the primary active for 8 cycles → `stall_req=1` after the 8th win; clears after the pop.
- Async reset with 3 entries buffered, mid-cycle → `fifo_count=0` and `busy_mask=0` immediately; no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle primary result with buffered multi-cycle results
// into one regfile write port. Optional macro WB_SEC_BYPASS_EN lets a secondary skip an empty FIFO.
module wb_arbiter #(
   parameter int DEPTH      = 4,
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst_s,
   input  logic                   pri_we,
   input  logic [AW-1:0]          pri_waddr,
   input  logic [DW-1:0]          pri_wdata,
   input  logic                   sec_valid,
   output logic                   sec_ready,
   input  logic [AW-1:0]          sec_waddr,
   input  logic [DW-1:0]          sec_wdata,
   output logic                   we,
   output logic [AW-1:0]          waddr,
   output logic [DW-1:0]          wdata,
   output logic [(1<<AW)-1:0]     busy_mask,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   stall_req
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int NR = 1 << AW;

   logic [AW-1:0]    addr_mem [DEPTH];
   logic [DW-1:0]    data_mem [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [SW-1:0]    starve_reg;

   logic pri_eff;
   logic fifo_empty;
   logic fifo_full;
   logic sec_hs;
   logic sec_nz;
   logic bypass;
   logic push;
   logic pop;

   assign pri_eff    = pri_we && (pri_waddr != '0);
   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == CW'(DEPTH));
   assign sec_ready  = !fifo_full && !rst_s;
   assign sec_hs     = sec_valid && sec_ready;
   assign sec_nz     = (sec_waddr != '0);

`ifdef WB_SEC_BYPASS_EN
   assign bypass = !pri_eff && fifo_empty && sec_hs && sec_nz;
`else
   assign bypass = 1'b0;
`endif

   // Address-0 secondaries complete the handshake but are dropped here.
   assign push = sec_hs && sec_nz && !bypass;
   assign pop  = !pri_eff && !fifo_empty && !rst_s;

   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (!rst_s) begin
         if (pri_eff) begin
            we    = 1'b1;
            waddr = pri_waddr;
            wdata = pri_wdata;
         end else if (!fifo_empty) begin
            we    = 1'b1;
            waddr = addr_mem[rd_ptr_reg];
            wdata = data_mem[rd_ptr_reg];
         end else if (bypass) begin
            we    = 1'b1;
            waddr = sec_waddr;
            wdata = sec_wdata;
         end
      end
   end

   // Payload storage needs no reset: entries are qualified by valid_reg.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= sec_waddr;
         data_mem[wr_ptr_reg] <= sec_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst_s) begin
      if (rst_s) begin
         valid_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         starve_reg <= '0;
      end else begin
         if (pop) begin
            valid_reg[rd_ptr_reg] <= 1'b0;
            rd_ptr_reg            <= rd_ptr_reg + 1'b1;
         end
         if (push) begin
            valid_reg[wr_ptr_reg] <= 1'b1;
            wr_ptr_reg            <= wr_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (fifo_empty || pop)
            starve_reg <= '0;
         else if (pri_eff && (starve_reg != SW'(STARVE_MAX)))
            starve_reg <= starve_reg + 1'b1;
      end
   end

   // Busy bit per register: OR over all valid entries that target it; r0 never busy.
   logic [NR-1:0] busy_bits;
   assign busy_bits[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < NR; gi++) begin : g_busy
         logic [DEPTH-1:0] match;
         for (genvar ge = 0; ge < DEPTH; ge++) begin : g_ent
            assign match[ge] = valid_reg[ge] && (addr_mem[ge] == AW'(gi));
         end
         assign busy_bits[gi] = |match;
      end
   endgenerate

   assign busy_mask  = busy_bits;
   assign fifo_count = count_reg;
   assign stall_req  = fifo_full || (starve_reg == SW'(STARVE_MAX));

endmodule
